uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_fifo.sv | 50 +++++
 rtl/uart_tx_cfg.sv | 137 +++++++++++++
 tb/tb_uart_tx_cfg.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity modes and config helpers.
// Used by both the TX and RX blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Out-of-range data-bit requests fall back to the widest frame the block supports.
  function automatic logic [3:0] eff_dbits(input logic [3:0] cfg, input logic [3:0] max_bits);
    return (cfg < 4'd5 || cfg > max_bits) ? max_bits : cfg;
  endfunction

  function automatic logic parity_on(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Small first-word-fall-through FIFO; dout always shows the oldest entry.
// Pushes while full and pops while empty are ignored.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: FIFO-fed, 5..DATA_W data bits, optional parity,
// one or two stop bits; frame config is latched when each word is popped.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OVS        = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_tick,
  input  logic [DATA_W-1:0]             i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [3:0]                    cfg_dbits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  output logic                          o_txd,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt
);

  localparam int TW = $clog2(OVS);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVS - 1);

  uart_state_t       state;
  logic [TW-1:0]     tick_cnt;
  logic [3:0]        bit_idx;
  logic [DATA_W-1:0] shreg;
  logic              par_acc;
  logic [3:0]        dbits_q;
  logic [1:0]        parity_q;
  logic              stop2_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              bit_end;
  logic              frame_end;
  logic              start_frame;

  uart_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (i_valid),
    .pop   (start_frame),
    .din   (i_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (o_fifo_cnt)
  );

  assign o_ready     = !fifo_full;
  assign o_busy      = (state != IDLE);
  assign bit_end     = (state != IDLE) && i_tick && (tick_cnt == TICK_LAST);
  assign frame_end   = (state == STOP) && bit_end && (!stop2_q || bit_idx[0]);
  assign start_frame = !fifo_empty && ((state == IDLE) || frame_end);

  // The next frame start overrides the STOP->IDLE return so frames run back to back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_acc  <= 1'b0;
      dbits_q  <= 4'(DATA_W);
      parity_q <= PAR_NONE;
      stop2_q  <= 1'b0;
      o_txd    <= 1'b1;
      o_done   <= 1'b0;
    end else begin
      o_done <= frame_end;
      if (state != IDLE && i_tick) tick_cnt <= bit_end ? '0 : tick_cnt + TW'(1);

      case (state)
        IDLE: ;
        START: if (bit_end) begin
          state   <= DATA;
          o_txd   <= shreg[0];
          shreg   <= shreg >> 1;
          bit_idx <= '0;
          par_acc <= 1'b0;
        end
        DATA: if (bit_end) begin
          par_acc <= par_acc ^ o_txd;
          if (bit_idx == dbits_q - 4'd1) begin
            bit_idx <= '0;
            if (parity_on(parity_q)) begin
              state <= PARITY;
              o_txd <= par_acc ^ o_txd ^ (parity_q == PAR_ODD);
            end else begin
              state <= STOP;
              o_txd <= 1'b1;
            end
          end else begin
            bit_idx <= bit_idx + 4'd1;
            o_txd   <= shreg[0];
            shreg   <= shreg >> 1;
          end
        end
        PARITY: if (bit_end) begin
          state   <= STOP;
          o_txd   <= 1'b1;
          bit_idx <= '0;
        end
        STOP: if (bit_end) begin
          if (!frame_end) begin
            bit_idx <= 4'd1;
          end else begin
            state <= IDLE;
            o_txd <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (start_frame) begin
        state    <= START;
        o_txd    <= 1'b0;
        shreg    <= fifo_dout;
        bit_idx  <= '0;
        tick_cnt <= '0;
        dbits_q  <= eff_dbits(cfg_dbits, 4'(DATA_W));
        parity_q <= cfg_parity;
        stop2_q  <= cfg_stop2;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: each accepted write queues its expected
// frame, and a line monitor decodes o_txd and compares bit levels and durations.
module tb_uart_tx_cfg;

  localparam int DATA_W     = 8;
  localparam int OVS        = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_tick;
  logic [DATA_W-1:0] i_data;
  logic              i_valid;
  logic              o_ready;
  logic [3:0]        cfg_dbits;
  logic [1:0]        cfg_parity;
  logic              cfg_stop2;
  logic              o_txd;
  logic              o_busy;
  logic              o_done;
  logic [CW-1:0]     o_fifo_cnt;

  typedef struct {
    logic [15:0] bits;
    int          len;
  } frame_t;

  frame_t sbQueue[$];
  frame_t cur;
  bit     active = 1'b0;
  int     sampleIdx = 0;
  int     matchCnt = 0;
  int     framesSeen = 0;
  int     doneCount = 0;
  int     gapSamples = 0;
  int     checks = 0;
  int     errors = 0;

  uart_tx_cfg #(
    .DATA_W     (DATA_W),
    .OVS        (OVS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_tick     (i_tick),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .cfg_dbits  (cfg_dbits),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .o_txd      (o_txd),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_fifo_cnt (o_fifo_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference frame: start, n data bits LSB first, optional parity, 1 or 2 stops.
  function automatic frame_t buildFrame(input logic [7:0] d, input logic [3:0] dbits,
                                        input logic [1:0] par, input logic stop2);
    frame_t f;
    int     n;
    int     pos;
    logic   p;
    n = (dbits < 5 || dbits > DATA_W) ? DATA_W : int'(dbits);
    f.bits = '1;
    f.bits[0] = 1'b0;
    p = 1'b0;
    pos = 1;
    for (int i = 0; i < n; i++) begin
      f.bits[pos] = d[i];
      p = p ^ d[i];
      pos++;
    end
    if (par == 2'b01) begin
      f.bits[pos] = p;
      pos++;
    end else if (par == 2'b10) begin
      f.bits[pos] = ~p;
      pos++;
    end
    f.bits[pos] = 1'b1;
    pos++;
    if (stop2) begin
      f.bits[pos] = 1'b1;
      pos++;
    end
    f.len = pos;
    return f;
  endfunction

  task automatic applyStimulus(input logic [7:0] d, input logic [3:0] dbits, input logic [1:0] par,
                               input logic stop2, input logic expectAccept);
    i_data  = d;
    i_valid = 1'b1;
    checkOutput("ready", o_ready, expectAccept);
    if (expectAccept) sbQueue.push_back(buildFrame(d, dbits, par, stop2));
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic waitIdle(input int maxCycles);
    int n;
    n = 0;
    while ((sbQueue.size() != 0 || active || o_busy) && n < maxCycles) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("idle_reached", (n < maxCycles), 1);
  endtask

  // Line monitor: each bit must hold its expected level for exactly OVS samples.
  always @(negedge clk) begin
    if (!reset) begin
      active = 1'b0;
    end else begin
      if (o_done) doneCount++;
      if (active && sampleIdx == OVS * cur.len) begin
        checkOutput("done_pulse", o_done, 1);
        active = 1'b0;
        framesSeen++;
      end
      if (!active && o_txd == 1'b0) begin
        if (sbQueue.size() == 0) begin
          checkOutput("unexpected_frame", 1, 0);
        end else begin
          cur = sbQueue.pop_front();
          active = 1'b1;
          sampleIdx = 0;
          matchCnt = 0;
        end
      end else if (!active && sbQueue.size() > 0) begin
        gapSamples++;
      end
      if (active) begin
        if (o_txd === cur.bits[sampleIdx / OVS]) matchCnt++;
        if (sampleIdx % OVS == OVS - 1) begin
          checkOutput($sformatf("bit%0d_level", sampleIdx / OVS), matchCnt, OVS);
          checkOutput("busy_in_frame", o_busy, 1);
          matchCnt = 0;
        end
        sampleIdx++;
      end
    end
  end

  initial begin
    int g0;
    int d0;
    int f0;
    reset      = 1'b0;
    i_tick     = 1'b1;
    i_valid    = 1'b0;
    i_data     = '0;
    cfg_dbits  = 4'd8;
    cfg_parity = 2'b00;
    cfg_stop2  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_txd", o_txd, 1);
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_done", o_done, 0);
    checkOutput("rst_cnt", o_fifo_cnt, 0);
    checkOutput("rst_ready", o_ready, 1);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("idle_no_frame", o_busy, 0);

    // Default 8N1 frame of 0xA5, start one edge after the write.
    applyStimulus(8'hA5, 4'd8, 2'b00, 1'b0, 1'b1);
    checkOutput("write_cnt", o_fifo_cnt, 1);
    checkOutput("write_busy", o_busy, 0);
    @(posedge clk);
    #1;
    checkOutput("latency_txd", o_txd, 0);
    checkOutput("latency_busy", o_busy, 1);
    checkOutput("latency_cnt", o_fifo_cnt, 0);
    waitIdle(400);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("idle_txd", o_txd, 1);

    // 7 data bits with even parity.
    cfg_dbits  = 4'd7;
    cfg_parity = 2'b01;
    applyStimulus(8'h53, 4'd7, 2'b01, 1'b0, 1'b1);
    waitIdle(400);

    // Odd parity with two stop bits.
    cfg_dbits  = 4'd8;
    cfg_parity = 2'b10;
    cfg_stop2  = 1'b1;
    applyStimulus(8'h00, 4'd8, 2'b10, 1'b1, 1'b1);
    waitIdle(400);

    // Out-of-range dbits and parity code 11 both fall back to defaults.
    cfg_dbits  = 4'd12;
    cfg_parity = 2'b11;
    cfg_stop2  = 1'b0;
    applyStimulus(8'h3C, 4'd12, 2'b11, 1'b0, 1'b1);
    waitIdle(400);

    // Five writes while idle, then a dropped write while full.
    cfg_dbits  = 4'd8;
    cfg_parity = 2'b00;
    d0 = doneCount;
    f0 = framesSeen;
    applyStimulus(8'h11, 4'd8, 2'b00, 1'b0, 1'b1);
    applyStimulus(8'h22, 4'd8, 2'b00, 1'b0, 1'b1);
    applyStimulus(8'h44, 4'd8, 2'b00, 1'b0, 1'b1);
    applyStimulus(8'h88, 4'd8, 2'b00, 1'b0, 1'b1);
    applyStimulus(8'hF0, 4'd8, 2'b00, 1'b0, 1'b1);
    checkOutput("full_cnt", o_fifo_cnt, FIFO_DEPTH);
    checkOutput("full_ready", o_ready, 0);
    g0 = gapSamples;
    applyStimulus(8'hFF, 4'd8, 2'b00, 1'b0, 1'b0);
    checkOutput("drop_cnt", o_fifo_cnt, FIFO_DEPTH);
    waitIdle(1200);
    checkOutput("no_gap", gapSamples - g0, 0);
    checkOutput("five_done", doneCount - d0, 5);
    checkOutput("five_frames", framesSeen - f0, 5);

    // Mid-frame cfg change only affects the following frame.
    applyStimulus(8'h96, 4'd8, 2'b00, 1'b0, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    applyStimulus(8'h1B, 4'd5, 2'b00, 1'b0, 1'b1);
    cfg_dbits = 4'd5;
    waitIdle(600);

    // Asynchronous reset during data bit 3, with a word still queued.
    cfg_dbits = 4'd8;
    applyStimulus(8'h00, 4'd8, 2'b00, 1'b0, 1'b1);
    applyStimulus(8'h00, 4'd8, 2'b00, 1'b0, 1'b1);
    checkOutput("push_pop_cnt", o_fifo_cnt, 1);
    repeat (70) @(posedge clk);
    #3;
    checkOutput("pre_rst_txd", o_txd, 0);
    reset = 1'b0;
    #1;
    checkOutput("async_txd", o_txd, 1);
    checkOutput("async_busy", o_busy, 0);
    checkOutput("async_done", o_done, 0);
    checkOutput("async_cnt", o_fifo_cnt, 0);
    checkOutput("async_ready", o_ready, 1);
    sbQueue.delete();
    @(posedge clk);
    #3;
    reset = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    checkOutput("post_rst_busy", o_busy, 0);
    checkOutput("post_rst_txd", o_txd, 1);
    applyStimulus(8'h5A, 4'd8, 2'b00, 1'b0, 1'b1);
    waitIdle(400);

    checkOutput("done_total", doneCount, framesSeen);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
